// File: rtl/sift_sub.sv
// EMD sifting subtractor: queues delayed signal samples and subtracts the
// mean envelope from them in arrival order, with saturation and sticky status flags.
module sift_sub #(
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    input  logic signed [DW-1:0] Xin_DEALY,
    input  logic                 Xin_VLD,
    input  logic signed [DW-1:0] Mean,
    input  logic                 Mean_VLD,
    output logic signed [DW-1:0] H_OUT,
    output logic                 H_VLD,
    output logic                 SAT,
    output logic                 OVF,
    output logic                 UDF,
    output logic [15:0]          CNT
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // Reset asserts asynchronously but is released on a clock edge
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic signed [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic                 empty_c;
    logic                 full_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 bypass_c;
    logic                 out_c;
    logic                 ovf_set_c;
    logic                 udf_set_c;
    logic                 sat_hi_c;
    logic                 sat_lo_c;
    logic signed [DW-1:0] operand_c;
    logic [DW:0]          diff_c;
    logic signed [DW-1:0] result_c;
    logic [CW-1:0]        count_nxt_c;

    // Occupancy decode, push/pop arbitration and saturating difference
    always_comb begin
        empty_c     = (count == '0);
        full_c      = (count == CW'(FIFO_DEPTH));
        bypass_c    = !CLR && empty_c && Xin_VLD && Mean_VLD;
        pop_c       = !CLR && Mean_VLD && !empty_c;
        push_c      = !CLR && Xin_VLD && !bypass_c && (!full_c || Mean_VLD);
        out_c       = pop_c || bypass_c;
        ovf_set_c   = !CLR && Xin_VLD && full_c && !Mean_VLD;
        udf_set_c   = !CLR && Mean_VLD && empty_c && !Xin_VLD;

        operand_c   = bypass_c ? Xin_DEALY : mem[rd_ptr];
        diff_c      = {operand_c[DW-1], operand_c} - {Mean[DW-1], Mean};
        sat_hi_c    = !diff_c[DW] &&  diff_c[DW-1];
        sat_lo_c    =  diff_c[DW] && !diff_c[DW-1];
        result_c    = diff_c[DW-1:0];
        if (sat_hi_c) result_c = {1'b0, {(DW-1){1'b1}}};
        if (sat_lo_c) result_c = {1'b1, {(DW-1){1'b0}}};

        count_nxt_c = count;
        if (push_c && !pop_c) count_nxt_c = count + CW'(1);
        if (pop_c && !push_c) count_nxt_c = count - CW'(1);
    end

    // Sample storage needs no reset; pointers define what is valid
    always_ff @(posedge CLK) begin
        if (push_c) mem[wr_ptr] <= Xin_DEALY;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            H_OUT  <= '0;
            H_VLD  <= 1'b0;
            SAT    <= 1'b0;
            OVF    <= 1'b0;
            UDF    <= 1'b0;
            CNT    <= '0;
        end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            H_VLD  <= 1'b0;
            SAT    <= 1'b0;
            OVF    <= 1'b0;
            UDF    <= 1'b0;
            CNT    <= '0;
        end else begin
            H_VLD  <= out_c;
            count  <= count_nxt_c;
            if (out_c) begin
                H_OUT <= result_c;
                CNT   <= CNT + 16'd1;
                if (sat_hi_c || sat_lo_c) SAT <= 1'b1;
            end
            if (ovf_set_c) OVF <= 1'b1;
            if (udf_set_c) UDF <= 1'b1;
            if (push_c)    wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
        end
    end

endmodule

// File: tb/tb_sift_sub.sv
// Directed bench for sift_sub: a reference FIFO model predicts each result,
// which is queued and compared when H_VLD fires.
module tb_sift_sub;

    logic               CLK;
    logic               RST_N;
    logic               CLR;
    logic signed [15:0] Xin_DEALY;
    logic               Xin_VLD;
    logic signed [15:0] Mean;
    logic               Mean_VLD;
    logic signed [15:0] H_OUT;
    logic               H_VLD;
    logic               SAT;
    logic               OVF;
    logic               UDF;
    logic [15:0]        CNT;

    sift_sub #(.DW(16), .FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .Xin_DEALY (Xin_DEALY),
        .Xin_VLD   (Xin_VLD),
        .Mean      (Mean),
        .Mean_VLD  (Mean_VLD),
        .H_OUT     (H_OUT),
        .H_VLD     (H_VLD),
        .SAT       (SAT),
        .OVF       (OVF),
        .UDF       (UDF),
        .CNT       (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    int mq[$];
    int exp_q[$];
    bit m_sat, m_ovf, m_udf;
    int m_cnt;
    int m_last;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_sat = 0;
        m_ovf = 0;
        m_udf = 0;
        m_cnt = 0;
    endtask

    // One clock of stimulus: update the model, drive, then check just after the edge
    task automatic cycle(input bit xv, input int x, input bit mv, input int m, input bit clr);
        bit have;
        int op;
        int d;
        have = 0;
        op   = 0;
        if (clr) begin
            model_clear();
        end else if (mv) begin
            if (mq.size() > 0) begin
                op   = mq.pop_front();
                have = 1;
                if (xv) mq.push_back(x);
            end else if (xv) begin
                op   = x;
                have = 1;
            end else begin
                m_udf = 1;
            end
        end else if (xv) begin
            if (mq.size() < 4) mq.push_back(x);
            else               m_ovf = 1;
        end
        if (have) begin
            d = op - m;
            if (d > 32767)  begin d = 32767;  m_sat = 1; end
            if (d < -32768) begin d = -32768; m_sat = 1; end
            exp_q.push_back(d);
            m_cnt  = (m_cnt + 1) & 32'hFFFF;
            m_last = d;
        end

        CLR       = clr;
        Xin_VLD   = xv;
        Xin_DEALY = 16'(x);
        Mean_VLD  = mv;
        Mean      = 16'(m);
        @(posedge CLK);
        #1;
        check("h_vld", 32'(H_VLD), (exp_q.size() > 0) ? 32'sd1 : 32'sd0);
        if (H_VLD && exp_q.size() > 0) check("h_out", H_OUT, exp_q.pop_front());
        else if (!H_VLD) check("h_out_hold", H_OUT, m_last);
        exp_q.delete();
        check("cnt", 32'(CNT), m_cnt);
        check("sat", 32'(SAT), 32'(m_sat));
        check("ovf", 32'(OVF), 32'(m_ovf));
        check("udf", 32'(UDF), 32'(m_udf));
        CLR      = 1'b0;
        Xin_VLD  = 1'b0;
        Mean_VLD = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h_out"}, H_OUT, 0);
        check({tag, "_h_vld"}, 32'(H_VLD), 0);
        check({tag, "_sat"}, 32'(SAT), 0);
        check({tag, "_ovf"}, 32'(OVF), 0);
        check({tag, "_udf"}, 32'(UDF), 0);
        check({tag, "_cnt"}, 32'(CNT), 0);
    endtask

    initial begin
        RST_N     = 1'b0;
        CLR       = 1'b0;
        Xin_VLD   = 1'b0;
        Xin_DEALY = '0;
        Mean_VLD  = 1'b0;
        Mean      = '0;
        model_clear();
        m_last    = 0;

        #12;
        check_all_zero("reset");
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Three queued samples minus a constant mean
        cycle(1, 100, 0, 0, 0);
        cycle(1, 200, 0, 0, 0);
        cycle(1, 300, 0, 0, 0);
        cycle(0, 0, 1, 10, 0);
        cycle(0, 0, 1, 10, 0);
        cycle(0, 0, 1, 10, 0);
        cycle(0, 0, 0, 0, 0);
        check("req030_cnt", 32'(CNT), 3);
        check("req030_h_out", H_OUT, 290);
        check("req030_flags", {29'd0, SAT, OVF, UDF}, 0);

        // Empty bypass
        cycle(1, -5, 1, 7, 0);
        check("bypass_h_out", H_OUT, -12);
        cycle(0, 0, 1, 1, 0);
        check("bypass_left_empty_udf", 32'(UDF), 1);
        cycle(0, 0, 0, 0, 1);

        // Saturation at both rails
        cycle(1, 32767, 1, -1, 0);
        check("sat_pos_h_out", H_OUT, 32767);
        check("sat_pos_flag", 32'(SAT), 1);
        cycle(1, -32768, 1, 1, 0);
        check("sat_neg_h_out", H_OUT, -32768);

        // Clear with concurrent traffic: clear wins, H_OUT retained
        cycle(1, 9, 1, 9, 1);
        check("clr_h_out_kept", H_OUT, -32768);
        check("clr_sat", 32'(SAT), 0);
        check("clr_cnt", 32'(CNT), 0);

        // Overflow drop, then only the first four come back
        for (int i = 1; i <= 5; i++) cycle(1, i, 0, 0, 0);
        check("ovf_flag", 32'(OVF), 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
        check("ovf_last_h_out", H_OUT, 4);
        cycle(0, 0, 1, 0, 0);
        check("ovf_drained_udf", 32'(UDF), 1);
        cycle(0, 0, 0, 0, 1);

        // Full with push and pop together
        for (int i = 1; i <= 4; i++) cycle(1, 10 * i, 0, 0, 0);
        cycle(1, 50, 1, 0, 0);
        check("full_pushpop_h_out", H_OUT, 10);
        check("full_pushpop_ovf", 32'(OVF), 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 5, 0);
        check("full_pushpop_tail", H_OUT, 45);
        check("full_pushpop_cnt", 32'(CNT), 5);

        // Underflow leaves count unchanged, clear zeros everything
        cycle(0, 0, 1, 3, 0);
        check("udf_flag", 32'(UDF), 1);
        check("udf_cnt", 32'(CNT), 5);
        cycle(0, 0, 0, 0, 1);
        check("clr_udf", 32'(UDF), 0);
        check("clr_cnt2", 32'(CNT), 0);

        // Asynchronous reset with samples queued
        cycle(1, 111, 0, 0, 0);
        cycle(1, 222, 0, 0, 0);
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        m_last = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        cycle(0, 0, 1, 5, 0);
        check("post_reset_udf", 32'(UDF), 1);
        check("post_reset_cnt", 32'(CNT), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sift_sub.md
SIFT_SUB -- requirements
Module: sift_sub

Interface
REQ-001 Parameter DW, default 16, is the sample width in bits, two's complement.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of delayed-sample slots; it SHALL be a power of two, at least 2.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port CLR, input, 1 bit: synchronous clear of FIFO, flags and counter.
REQ-006 Port Xin_DEALY, input, DW bits signed: delayed signal sample from the delay line.
REQ-007 Port Xin_VLD, input, 1 bit: Xin_DEALY is valid this cycle (push).
REQ-008 Port Mean, input, DW bits signed: mean-envelope sample.
REQ-009 Port Mean_VLD, input, 1 bit: Mean is valid this cycle (pop and compute).
REQ-010 Port H_OUT, output, DW bits signed: registered sifting result (Xin_DEALY minus Mean).
REQ-011 Port H_VLD, output, 1 bit: single-cycle pulse qualifying H_OUT.
REQ-012 Port SAT, output, 1 bit: sticky flag, a result was saturated.
REQ-013 Port OVF, output, 1 bit: sticky flag, a push was dropped because the FIFO was full.
REQ-014 Port UDF, output, 1 bit: sticky flag, Mean arrived with no delayed sample available.
REQ-015 Port CNT, output, 16 bits: count of H_VLD pulses since reset or clear.

Function
REQ-016 Each Xin_VLD cycle SHALL write Xin_DEALY into the FIFO tail; each Mean_VLD cycle SHALL pair Mean with the FIFO head, oldest first.
REQ-017 Occupancy states: EMPTY (0), PARTIAL (1..FIFO_DEPTH-1), FULL (FIFO_DEPTH); occupancy SHALL change by +1 on push only, -1 on pop only, 0 on push+pop or neither.
REQ-018 EMPTY with Xin_VLD and Mean_VLD in the same cycle: bypass; pair Mean with the current Xin_DEALY directly; occupancy stays 0.
REQ-019 EMPTY with Mean_VLD and no Xin_VLD: no output; set UDF; occupancy stays 0.
REQ-020 FULL with Xin_VLD and no Mean_VLD: drop the incoming sample; set OVF; FIFO contents unchanged.
REQ-021 FULL with Xin_VLD and Mean_VLD: pop head and push new sample in the same cycle; no flag set.
REQ-022 Difference SHALL be formed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1]; SAT SHALL be set whenever clamping occurs.
REQ-023 Latency: H_OUT and H_VLD SHALL appear on the clock edge following the Mean_VLD cycle (1 cycle); H_OUT SHALL hold its last value while H_VLD is low.
REQ-024 CNT SHALL increment on every H_VLD pulse and wrap from 65535 to 0.
REQ-025 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-026 CLR SHALL take priority over Xin_VLD and Mean_VLD in the same cycle: it empties the FIFO and zeroes SAT, OVF, UDF, CNT and H_VLD; H_OUT is retained.

Reset
REQ-027 RST_N low SHALL immediately force H_OUT=0, H_VLD=0, SAT=0, OVF=0, UDF=0, CNT=0, pointers=0, occupancy=EMPTY.
REQ-028 Reset asserted mid-operation SHALL discard all FIFO contents and any pending result; the first Mean_VLD after release with no prior push SHALL set UDF.
REQ-029 Release of RST_N SHALL be synchronised so the first active edge sees a clean deassertion.

Verification
REQ-030 Push 100, 200, 300 on consecutive cycles, then Mean=10 for three cycles -> H_OUT 90, 190, 290 on the following three edges, CNT=3, no flags.
REQ-031 EMPTY, Xin_DEALY=-5 and Mean=7 in the same cycle -> H_OUT=-12 one cycle later, occupancy 0.
REQ-032 Xin_DEALY=32767, Mean=-1 -> H_OUT=32767, SAT=1; Xin_DEALY=-32768, Mean=1 -> H_OUT=-32768.
REQ-033 Five pushes with no Mean (depth 4) -> OVF=1; four Mean pops return the first four samples only.
REQ-034 Mean_VLD while EMPTY with no push -> UDF=1, no H_VLD, CNT unchanged; CLR pulse -> all flags and CNT zero.
REQ-035 Two samples queued, RST_N pulsed low mid-stream -> all outputs 0 asynchronously; next Mean_VLD -> UDF=1.
